// File: rtl/wb_xbar_pkg.sv
// Shared definitions for the Wishbone crossbar.
// Provides:
//   - the default address map (ROM 0x0000, RAM 0x1000, IO 0x8000, 4 KiB windows)
//   - the per-slave arbiter state encoding
//   - the read-data value returned with an error (all zeros)
package wb_xbar_pkg;

    localparam logic [15:0] ROM_BASE = 16'h0000;
    localparam logic [15:0] RAM_BASE = 16'h1000;
    localparam logic [15:0] IO_BASE  = 16'h8000;
    localparam logic [15:0] WIN_MASK = 16'hF000;

    // Slave 0 sits in the least significant bits of the packed vectors.
    localparam logic [47:0] DEF_SLV_BASE = {IO_BASE, RAM_BASE, ROM_BASE};
    localparam logic [47:0] DEF_SLV_MASK = {WIN_MASK, WIN_MASK, WIN_MASK};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    // Each bit of the read data returned on an error or to an ungranted master.
    localparam logic ERR_RDATA_BIT = 1'b0;

endpackage

// File: rtl/wb_rr_arb.sv
// Round-robin arbiter for one crossbar slave.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   req[NM]      masters currently addressing this slave
//   release_req  owner has dropped cyc (or the watchdog fired)
//   grant[NM]    registered one-hot grant, all zero when idle
//   owner        index of the master that owns (or last owned) the slave
//   ptr          rotating priority pointer, first master considered when idle
module wb_rr_arb
    import wb_xbar_pkg::*;
#(
    parameter int NM = 3,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [NM-1:0] req,
    input  logic          release_req,
    output logic [NM-1:0] grant,
    output logic [IW-1:0] owner,
    output logic [IW-1:0] ptr
);

    arb_state_e    state_r, state_n;
    logic [IW-1:0] owner_r, owner_n;
    logic [IW-1:0] ptr_r, ptr_n;
    logic [NM-1:0] grant_r, grant_n;
    logic [IW-1:0] pick_s;
    logic          pick_vld_s;

    // Pick the first requester at or after the pointer; scanning farthest
    // first lets the nearest requester overwrite the choice.
    always_comb begin
        logic [IW:0] sum;
        logic [IW-1:0] idx;
        pick_s     = ptr_r;
        pick_vld_s = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int off = NM - 1; off >= 0; off--) begin
            sum = {1'b0, ptr_r} + (IW+1)'(off);
            if (sum >= (IW+1)'(NM)) begin
                idx = IW'(sum - (IW+1)'(NM));
            end else begin
                idx = sum[IW-1:0];
            end
            if (req[idx]) begin
                pick_s     = idx;
                pick_vld_s = 1'b1;
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // Next-state logic; the pointer only moves on a release.
    always_comb begin
        state_n = state_r;
        owner_n = owner_r;
        ptr_n   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    state_n = ST_OWNED;
                    owner_n = pick_s;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_OWNED: begin
                if (release_req) begin
                    state_n = ST_IDLE;
                    if (owner_r == IW'(NM - 1)) begin
                        ptr_n = '0;
                    end else begin
                        ptr_n = owner_r + IW'(1);
                    end
                end else begin
                    state_n = ST_OWNED;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        grant_n = '0;
        if (state_n == ST_OWNED) begin
            grant_n[owner_n] = 1'b1;
        end else begin
            grant_n = '0;
        end
    end

    // State, owner, pointer and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            owner_r <= '0;
            ptr_r   <= '0;
            grant_r <= '0;
        end else begin
            state_r <= state_n;
            owner_r <= owner_n;
            ptr_r   <= ptr_n;
            grant_r <= grant_n;
        end
    end

    assign grant = grant_r;
    assign owner = owner_r;
    assign ptr   = ptr_r;

endmodule

// File: rtl/wb_xbar.sv
// NM x NS classic Wishbone crossbar with one round-robin arbiter per slave.
// Ports:
//   sys_clk, sys_rst            clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i      master cycle, strobe, write enable (NM)
//   m_addr_i/m_data_i           master address (NM*AW) and write data (NM*DW)
//   m_ack_o/m_err_o/m_stall_o   master ack, error (decode miss or timeout), stall
//   m_data_o                    master read data (NM*DW), zero when not granted
//   s_cyc_o/s_stb_o/s_we_o      slave cycle, strobe, write enable (NS)
//   s_addr_o/s_data_o           slave address (NS*AW) and write data (NS*DW)
//   s_ack_i/s_data_i            slave ack (NS) and read data (NS*DW)
// Optional feature macro: WB_XBAR_TIMEOUT_EN adds a per-slave watchdog that
// errors and releases a transfer whose strobe goes unacknowledged for
// TIMEOUT cycles.
module wb_xbar
    import wb_xbar_pkg::*;
#(
    parameter int NM = 3,
    parameter int NS = 3,
    parameter int AW = 16,
    parameter int DW = 32,
    parameter logic [NS*AW-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [NS*AW-1:0] SLV_MASK = DEF_SLV_MASK,
    parameter int TIMEOUT = 255
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM*AW-1:0] m_addr_i,
    input  logic [NM*DW-1:0] m_data_i,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [NM-1:0]    m_stall_o,
    output logic [NM*DW-1:0] m_data_o,
    output logic [NS-1:0]    s_cyc_o,
    output logic [NS-1:0]    s_stb_o,
    output logic [NS-1:0]    s_we_o,
    output logic [NS*AW-1:0] s_addr_o,
    output logic [NS*DW-1:0] s_data_o,
    input  logic [NS-1:0]    s_ack_i,
    input  logic [NS*DW-1:0] s_data_i
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;

    logic [NM-1:0] hit_any_s, req_s, miss_s, blocked_s, to_hit_s;
    logic [SW-1:0] sel_s [NM];
    logic [NM-1:0] arb_req_s [NS];
    logic [NM-1:0] grant_s [NS];
    logic [IW-1:0] owner_s [NS];
    logic [IW-1:0] ptr_s [NS];
    logic [NS-1:0] owned_s, release_s, tmo_s;
    logic [NM-1:0] err_r, miss_seen_r;

    // Address decode: scan from the highest slave down so the lowest match wins.
    always_comb begin
        logic          hit;
        logic [SW-1:0] sel;
        for (int i = 0; i < NM; i++) begin
            hit = 1'b0;
            sel = '0;
            for (int j = NS - 1; j >= 0; j--) begin
                if ((m_addr_i[i*AW +: AW] & SLV_MASK[j*AW +: AW]) == SLV_BASE[j*AW +: AW]) begin
                    hit = 1'b1;
                    sel = SW'(j);
                end else begin
                    hit = hit;
                end
            end
            hit_any_s[i] = hit;
            sel_s[i]     = sel;
            req_s[i]     = m_cyc_i[i] & m_stb_i[i] & hit & ~blocked_s[i];
            miss_s[i]    = m_cyc_i[i] & m_stb_i[i] & ~hit;
        end
    end

    // Route each decoded request to the arbiter of its target slave.
    always_comb begin
        for (int j = 0; j < NS; j++) begin
            for (int i = 0; i < NM; i++) begin
                arb_req_s[j][i] = req_s[i] & (sel_s[i] == SW'(j));
            end
        end
    end

    for (genvar j = 0; j < NS; j++) begin : g_arb
        wb_rr_arb #(
            .NM (NM),
            .IW (IW)
        ) u_arb (
            .clk         (sys_clk),
            .rst_n       (sys_rst),
            .req         (arb_req_s[j]),
            .release_req (release_s[j]),
            .grant       (grant_s[j]),
            .owner       (owner_s[j]),
            .ptr         (ptr_s[j])
        );
        assign owned_s[j]   = |grant_s[j];
        assign release_s[j] = (owned_s[j] & ~m_cyc_i[owner_s[j]]) | tmo_s[j];
    end

    // Slave-side mux: the owner's signals pass straight through, idle slaves see zeros.
    always_comb begin
        s_cyc_o  = '0;
        s_stb_o  = '0;
        s_we_o   = '0;
        s_addr_o = '0;
        s_data_o = '0;
        for (int j = 0; j < NS; j++) begin
            if (owned_s[j]) begin
                s_cyc_o[j]           = m_cyc_i[owner_s[j]];
                s_stb_o[j]           = m_stb_i[owner_s[j]];
                s_we_o[j]            = m_we_i[owner_s[j]];
                s_addr_o[j*AW +: AW] = m_addr_i[owner_s[j]*AW +: AW];
                s_data_o[j*DW +: DW] = m_data_i[owner_s[j]*DW +: DW];
            end else begin
                s_cyc_o[j] = 1'b0;
            end
        end
    end

    // Master-side return path: ack and read data from whichever slave granted it.
    always_comb begin
        m_ack_o   = '0;
        m_data_o  = {(NM*DW){ERR_RDATA_BIT}};
        m_stall_o = '0;
        for (int i = 0; i < NM; i++) begin
            for (int j = 0; j < NS; j++) begin
                m_ack_o[i]           = m_ack_o[i] | (s_ack_i[j] & grant_s[j][i]);
                m_data_o[i*DW +: DW] = m_data_o[i*DW +: DW] | (s_data_i[j*DW +: DW] & {DW{grant_s[j][i]}});
            end
            m_stall_o[i] = req_s[i] & ~grant_s[sel_s[i]][i];
        end
    end

    // Error pulse: one cycle per decode miss (re-armed only when stb drops) or timeout.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            err_r       <= '0;
            miss_seen_r <= '0;
        end else begin
            err_r       <= (miss_s & ~miss_seen_r) | to_hit_s;
            miss_seen_r <= miss_s;
        end
    end

    assign m_err_o = err_r;

`ifdef WB_XBAR_TIMEOUT_EN
    localparam int CW = 16;

    logic [CW-1:0] wd_r [NS];
    logic [NM-1:0] blocked_r;

    // Watchdog fires on the last unacknowledged strobe cycle; the owner is
    // also flagged so the err pulse lines up with the release edge.
    always_comb begin
        tmo_s    = '0;
        to_hit_s = '0;
        for (int j = 0; j < NS; j++) begin
            if (owned_s[j] && s_stb_o[j] && !s_ack_i[j] && (wd_r[j] == CW'(TIMEOUT - 1))) begin
                tmo_s[j] = 1'b1;
            end else begin
                tmo_s[j] = 1'b0;
            end
        end
        for (int i = 0; i < NM; i++) begin
            for (int j = 0; j < NS; j++) begin
                to_hit_s[i] = to_hit_s[i] | (tmo_s[j] & grant_s[j][i]);
            end
        end
    end

    // Per-slave watchdog counters: count stalled strobes, clear on ack or release.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            for (int j = 0; j < NS; j++) begin
                wd_r[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NS; j++) begin
                if (!owned_s[j] || s_ack_i[j] || release_s[j]) begin
                    wd_r[j] <= '0;
                end else if (s_stb_o[j]) begin
                    wd_r[j] <= wd_r[j] + CW'(1);
                end else begin
                    wd_r[j] <= wd_r[j];
                end
            end
        end
    end

    // A timed-out master stays locked out until it ends its bus cycle.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            blocked_r <= '0;
        end else begin
            for (int i = 0; i < NM; i++) begin
                if (!m_cyc_i[i]) begin
                    blocked_r[i] <= 1'b0;
                end else if (to_hit_s[i]) begin
                    blocked_r[i] <= 1'b1;
                end else begin
                    blocked_r[i] <= blocked_r[i];
                end
            end
        end
    end

    assign blocked_s = blocked_r;
`else
    assign tmo_s     = '0;
    assign to_hit_s  = '0;
    assign blocked_s = '0;
`endif

endmodule

// File: tb/tb_wb_xbar.sv
// Self-checking bench for wb_xbar (3 masters, 3 slaves, default map).
// Slave responses are driven directly; expected read data is queued when a
// response is driven and compared when the matching master sees its ack.
module tb_wb_xbar;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [2:0]  m_cyc = '0, m_stb = '0, m_we = '0;
    logic [47:0] m_addr = '0;
    logic [95:0] m_wdata = '0;
    logic [2:0]  m_ack, m_err, m_stall;
    logic [95:0] m_rdata;
    logic [2:0]  s_cyc, s_stb, s_we;
    logic [47:0] s_addr;
    logic [95:0] s_wdata;
    logic [2:0]  s_ack = '0;
    logic [95:0] s_rdata = '0;

    typedef struct {
        int unsigned mst;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_xbar #(.TIMEOUT(4)) dut (
        .sys_clk   (clk),
        .sys_rst   (sys_rst),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_we_i    (m_we),
        .m_addr_i  (m_addr),
        .m_data_i  (m_wdata),
        .m_ack_o   (m_ack),
        .m_err_o   (m_err),
        .m_stall_o (m_stall),
        .m_data_o  (m_rdata),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_addr_o  (s_addr),
        .s_data_o  (s_wdata),
        .s_ack_i   (s_ack),
        .s_data_i  (s_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int m, input logic [31:0] d);
        exp_t e;
        e.mst  = m;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Pop one expectation for every master currently acked.
    task automatic sb_check();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (m_ack[i]) begin
                chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_master", 64'(i), 64'(e.mst));
                    chk("sb_data", 64'(m_rdata[i*32 +: 32]), 64'(e.data));
                end
            end
        end
    endtask

    task automatic run_single(input int m, input logic [15:0] addr, input int sl, input logic [31:0] data);
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        m_addr[m*16 +: 16] = addr;
        #1;
        chk("idle_stb", 64'(s_stb[sl]), 64'd0);
        chk("req_stall", 64'(m_stall[m]), 64'd1);
        step();
        #1;
        chk("gnt_stb", 64'(s_stb[sl]), 64'd1);
        chk("gnt_addr", 64'(s_addr[sl*16 +: 16]), 64'(addr));
        chk("gnt_stall", 64'(m_stall[m]), 64'd0);
        s_ack[sl] = 1'b1;
        s_rdata[sl*32 +: 32] = data;
        push(m, data);
        #1;
        chk("ack", 64'(m_ack), 64'(3'b001 << m));
        sb_check();
        step();
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
        s_ack[sl] = 1'b0;
        step();
    endtask

    task automatic run_contend(input logic [2:0] mask, input logic [15:0] addr,
                               input int first, input int second, input int sl);
        logic [2:0] st;
        logic [31:0] d;
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                m_cyc[i] = 1'b1;
                m_stb[i] = 1'b1;
                m_addr[i*16 +: 16] = addr + 16'(i * 4);
            end
        end
        #1;
        chk("ct_stall_idle", 64'(m_stall), 64'(mask));
        step();
        #1;
        st = mask;
        st[first] = 1'b0;
        chk("ct_first_addr", 64'(s_addr[sl*16 +: 16]), 64'(addr + 16'(first * 4)));
        chk("ct_first_stall", 64'(m_stall), 64'(st));
        d = {16'hC0DE, 8'(sl), 8'(first)};
        s_ack[sl] = 1'b1;
        s_rdata[sl*32 +: 32] = d;
        push(first, d);
        #1;
        sb_check();
        step();
        m_cyc[first] = 1'b0;
        m_stb[first] = 1'b0;
        s_ack[sl] = 1'b0;
        #1;
        chk("ct_drop_cyc", 64'(s_cyc[sl]), 64'd0);
        step();
        #1;
        chk("ct_bubble", 64'(s_cyc[sl]), 64'd0);
        chk("ct_bubble_stall", 64'(m_stall[second]), 64'd1);
        step();
        #1;
        chk("ct_second_cyc", 64'(s_cyc[sl]), 64'd1);
        chk("ct_second_addr", 64'(s_addr[sl*16 +: 16]), 64'(addr + 16'(second * 4)));
        d = {16'hC0DE, 8'(sl), 8'(second)};
        s_ack[sl] = 1'b1;
        s_rdata[sl*32 +: 32] = d;
        push(second, d);
        #1;
        sb_check();
        step();
        m_cyc = '0;
        m_stb = '0;
        s_ack = '0;
        step();
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_scyc", 64'(s_cyc), 64'd0);
        chk("rst_ack", 64'(m_ack), 64'd0);
        chk("rst_err", 64'(m_err), 64'd0);
        chk("rst_rdata", 64'(m_rdata[63:0]), 64'd0);
        chk("rst_stall", 64'(m_stall), 64'd0);
        step();
        sys_rst = 1'b1;

        // Single read, ack/data with zero added latency
        run_single(0, 16'h0010, 0, 32'hCAFEBABE);

        // Contention on RAM: pointer 0 -> m0 then m1; pointer 2 wraps -> m0 then m1;
        // pointer 2 with m1,m2 -> m2 then m1
        run_contend(3'b011, 16'h1004, 0, 1, 1);
        run_contend(3'b011, 16'h1004, 0, 1, 1);
        run_contend(3'b110, 16'h1004, 2, 1, 1);

        // Concurrent traffic to ROM (read) and IO (write)
        m_cyc = 3'b101;
        m_stb = 3'b101;
        m_we[2] = 1'b1;
        m_addr[15:0] = 16'h0000;
        m_addr[47:32] = 16'h8000;
        m_wdata[95:64] = 32'h12345678;
        #1;
        chk("conc_stall_idle", 64'(m_stall), 64'b101);
        step();
        #1;
        chk("conc_stb", 64'(s_stb), 64'b101);
        chk("conc_stall", 64'(m_stall), 64'd0);
        chk("conc_we", 64'(s_we), 64'b100);
        chk("conc_wdata", 64'(s_wdata[95:64]), 64'h12345678);
        s_ack = 3'b101;
        s_rdata[31:0] = 32'h0A0A0A0A;
        s_rdata[95:64] = 32'h5A5A5A5A;
        push(0, 32'h0A0A0A0A);
        push(2, 32'h5A5A5A5A);
        #1;
        chk("conc_ack", 64'(m_ack), 64'b101);
        sb_check();
        step();
        m_cyc = '0;
        m_stb = '0;
        m_we = '0;
        s_ack = '0;
        step();

        // Decode miss: single err pulse, no slave activity
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        m_addr[31:16] = 16'h4000;
        #1;
        chk("miss_err_early", 64'(m_err), 64'd0);
        chk("miss_stall", 64'(m_stall), 64'd0);
        step();
        #1;
        chk("miss_err", 64'(m_err), 64'b010);
        chk("miss_rdata", 64'(m_rdata[63:32]), 64'd0);
        chk("miss_scyc", 64'(s_cyc), 64'd0);
        step();
        #1;
        chk("miss_no_repeat", 64'(m_err), 64'd0);
        chk("miss_scyc2", 64'(s_cyc), 64'd0);
        m_cyc = '0;
        m_stb = '0;
        step();

        // Reset mid-transfer: move RAM pointer to 1, let m1 own, then reset
        run_single(0, 16'h1010, 1, 32'h0BADF00D);
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        m_addr[31:16] = 16'h1020;
        step();
        #1;
        chk("pre_rst_stb", 64'(s_stb[1]), 64'd1);
        sys_rst = 1'b0;
        #1;
        chk("rst_mid_cyc", 64'(s_cyc), 64'd0);
        chk("rst_mid_stb", 64'(s_stb), 64'd0);
        chk("rst_mid_addr", 64'(s_addr), 64'd0);
        chk("rst_mid_stall", 64'(m_stall), 64'b010);
        step();
        m_cyc = '0;
        m_stb = '0;
        step();
        sys_rst = 1'b1;
        run_contend(3'b011, 16'h1000, 0, 1, 1);

`ifdef WB_XBAR_TIMEOUT_EN
        // IO never acks: err 4 cycles after first strobe, waiting m1 then granted
        m_cyc = 3'b011;
        m_stb = 3'b011;
        m_addr[15:0] = 16'h8000;
        m_addr[31:16] = 16'h8004;
        step();
        #1;
        chk("to_stb0", 64'(s_stb[2]), 64'd1);
        chk("to_addr0", 64'(s_addr[47:32]), 64'h8000);
        for (int k = 1; k < 4; k++) begin
            step();
            #1;
            chk("to_err_quiet", 64'(m_err), 64'd0);
            chk("to_stb_held", 64'(s_stb[2]), 64'd1);
        end
        step();
        #1;
        chk("to_err", 64'(m_err), 64'b001);
        chk("to_released", 64'(s_stb[2]), 64'd0);
        chk("to_rdata", 64'(m_rdata[31:0]), 64'd0);
        step();
        #1;
        chk("to_err_once", 64'(m_err), 64'd0);
        chk("to_next_stb", 64'(s_stb[2]), 64'd1);
        chk("to_next_addr", 64'(s_addr[47:32]), 64'h8004);
        s_ack[2] = 1'b1;
        s_rdata[95:64] = 32'h600DD00D;
        push(1, 32'h600DD00D);
        #1;
        sb_check();
        step();
        m_cyc = '0;
        m_stb = '0;
        s_ack = '0;
        step();
`endif

        chk("sb_left", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
